// File: rtl/usr_shift_sequencer.sv
// Command sequencer for a WIDTH-bit universal shift register: accepts LOAD/SHR/SHL/ROR/ROL
// commands over valid/ready and drives the register's sel/i/il/ir controls, then pulses done.
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_i,
    output logic             sr_il,
    output logic             sr_ir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_LOAD) || op_is_shift(op);
    endfunction

    function automatic logic op_moves_right(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_ROR);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;

    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] sr_i_q, sr_i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             il_s, ir_s;

    // Next state and command latch; fields are captured only on an IDLE handshake
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    cnt_d  = cmd_cnt;
                    fill_d = cmd_fill;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (op_is_shift(cmd_op) && (cmd_cnt != CNT_ZERO)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            ST_SHIFT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the controls leave the block registered
    always_comb begin
        sel_d  = SEL_HOLD;
        sr_i_d = DATA_ZERO;
        case (state_d)
            ST_LOAD: begin
                sel_d  = SEL_LOAD;
                sr_i_d = data_d;
            end
            ST_SHIFT: begin
                if (op_moves_right(op_d)) begin
                    sel_d = SEL_SHR;
                end else begin
                    sel_d = SEL_SHL;
                end
            end
            default: begin
                sel_d  = SEL_HOLD;
                sr_i_d = DATA_ZERO;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_DONE) && !op_is_legal(op_d);
    end

    // Serial inputs follow the live register contents, so they cannot be registered
    always_comb begin
        il_s = 1'b0;
        ir_s = 1'b0;
        if (state_q == ST_SHIFT) begin
            case (op_q)
                OP_SHR:  ir_s = fill_q;
                OP_SHL:  il_s = fill_q;
                OP_ROR:  ir_s = sr_q[0];
                OP_ROL:  il_s = sr_q[WIDTH-1];
                default: begin
                    il_s = 1'b0;
                    ir_s = 1'b0;
                end
            endcase
        end else begin
            il_s = 1'b0;
            ir_s = 1'b0;
        end
    end

    // State, latched command and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            data_q  <= DATA_ZERO;
            cnt_q   <= CNT_ZERO;
            fill_q  <= 1'b0;
            sel_q   <= SEL_HOLD;
            sr_i_q  <= DATA_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            sel_q   <= sel_d;
            sr_i_q  <= sr_i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign sr_sel    = sel_q;
    assign sr_i      = sr_i_q;
    assign sr_il     = il_s;
    assign sr_ir     = ir_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: shift-register environment, command-level reference model,
// per-cycle output compare, directed scenarios and randomized commands.
module tb_usr_shift_sequencer;

    localparam int W = 4;
    localparam int C = 3;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic [C-1:0] cmd_cnt = '0;
    logic         cmd_fill = 1'b0;
    logic [W-1:0] sr_reg = '0;
    logic [1:0]   sr_sel;
    logic [W-1:0] sr_i;
    logic         sr_il, sr_ir, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    bit chk_en   = 1'b0;

    usr_shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .sr_q(sr_reg), .sr_sel(sr_sel), .sr_i(sr_i), .sr_il(sr_il), .sr_ir(sr_ir),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // The controlled universal shift register (no reset: it keeps its value across rst)
    always @(posedge clk) begin
        case (sr_sel)
            2'b01:   sr_reg <= {sr_ir, sr_reg[W-1:1]};
            2'b10:   sr_reg <= {sr_reg[W-2:0], sr_il};
            2'b11:   sr_reg <= sr_i;
            default: sr_reg <= sr_reg;
        endcase
    end

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] i;
        logic         busy, done, err, il, ir, chk_q;
        logic [W-1:0] q_exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t idle_e;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
        int m;
        m = n % W;
        if (m == 0) return v;
        return (v >> m) | (v << (W - m));
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
        return rotr(v, W - (n % W));
    endfunction

    function automatic logic [W-1:0] shr(input logic [W-1:0] v, input int n, input logic f);
        logic [W-1:0] mask;
        if (n >= W) return {W{f}};
        mask = ~(ALL1 >> n);
        return (v >> n) | (f ? mask : '0);
    endfunction

    function automatic logic [W-1:0] shl(input logic [W-1:0] v, input int n, input logic f);
        logic [W-1:0] mask;
        if (n >= W) return {W{f}};
        mask = ~(ALL1 << n);
        return (v << n) | (f ? mask : '0);
    endfunction

    // Expected per-cycle output trace of one accepted command
    task automatic build_trace(input logic [2:0] op, input logic [W-1:0] data,
                               input int cnt, input logic f, input logic [W-1:0] start);
        exp_t e;
        logic [W-1:0] v;
        logic [W-1:0] fin;
        fin = start;
        if (op == 3'd0) begin
            e = idle_e; e.busy = 1'b1; e.sel = 2'b11; e.i = data;
            exp_q.push_back(e);
            fin = data;
        end else if (op <= 3'd4 && cnt > 0) begin
            for (int j = 0; j < cnt; j++) begin
                e = idle_e; e.busy = 1'b1;
                e.sel = (op == 3'd1 || op == 3'd3) ? 2'b01 : 2'b10;
                case (op)
                    3'd1: e.ir = f;
                    3'd2: e.il = f;
                    3'd3: begin v = rotr(start, j); e.ir = v[0]; end
                    default: begin v = rotl(start, j); e.il = v[W-1]; end
                endcase
                exp_q.push_back(e);
            end
            case (op)
                3'd1: fin = shr(start, cnt, f);
                3'd2: fin = shl(start, cnt, f);
                3'd3: fin = rotr(start, cnt);
                default: fin = rotl(start, cnt);
            endcase
        end
        e = idle_e; e.busy = 1'b1; e.done = 1'b1; e.err = (op > 3'd4);
        e.chk_q = 1'b1; e.q_exp = fin;
        exp_q.push_back(e);
    endtask

    initial begin
        idle_e = '{sel: 2'b00, i: '0, busy: 1'b0, done: 1'b0, err: 1'b0,
                   il: 1'b0, ir: 1'b0, chk_q: 1'b0, q_exp: '0};
        cur = idle_e;
    end

    // Reference model: accepts whenever it is idle and valid is up, then replays the trace
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            cur = idle_e;
        end else begin
            if (!cur.busy && cmd_valid) begin
                build_trace(cmd_op, cmd_data, int'(cmd_cnt), cmd_fill, sr_reg);
                acc_cnt++;
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = idle_e;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  8'(busy),   8'(cur.busy));
            check("done",  8'(done),   8'(cur.done));
            check("err",   8'(err),    8'(cur.err));
            check("sel",   8'(sr_sel), 8'(cur.sel));
            check("sr_i",  8'(sr_i),   8'(cur.i));
            check("il",    8'(sr_il),  8'(cur.il));
            check("ir",    8'(sr_ir),  8'(cur.ir));
            if (rst) check("ready", 8'(cmd_ready), 8'(!cur.busy));
            if (cur.chk_q) check("sr_q_done", 8'(sr_reg), 8'(cur.q_exp));
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] data,
                        input logic [C-1:0] cnt, input logic f);
        int a0;
        int k;
        a0 = acc_cnt;
        k = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = f;
        while (acc_cnt == a0 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        if (acc_cnt == a0) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
        end
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_data = W'($urandom); cmd_cnt = C'($urandom);
        cmd_fill = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (cur.busy && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (cur.busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int a0;
        int gap;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        send(3'd0, 4'b1011, 3'd0, 1'b0); wait_idle();
        check("pin_load", 8'(sr_reg), 8'h0B);
        send(3'd1, 4'b0000, 3'd2, 1'b1); wait_idle();
        check("pin_shr2", 8'(sr_reg), 8'h0E);
        send(3'd0, 4'b1001, 3'd0, 1'b0); wait_idle();
        send(3'd4, 4'b0000, 3'd5, 1'b0); wait_idle();
        check("pin_rol5", 8'(sr_reg), 8'h03);
        send(3'd2, 4'b0000, 3'd0, 1'b1); wait_idle();
        send(3'd6, 4'b1111, 3'd3, 1'b1); wait_idle();
        check("pin_untouched", 8'(sr_reg), 8'h03);

        a0 = acc_cnt;
        send(3'd1, 4'b0000, 3'd3, 1'b0);
        send(3'd0, 4'b0101, 3'd0, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("accept_once", 8'(acc_cnt - a0), 8'd2);
        check("pin_held_load", 8'(sr_reg), 8'h05);

        send(3'd0, 4'b1111, 3'd0, 1'b0); wait_idle();
        send(3'd2, 4'b0000, 3'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        repeat (3) @(posedge clk);
        #1;
        send(3'd0, 4'b0110, 3'd0, 1'b0); wait_idle();
        check("pin_load_after_rst", 8'(sr_reg), 8'h06);

        for (int n = 0; n < 300; n++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), C'($urandom), 1'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                pulse_reset();
            end else if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                gap = $urandom_range(0, 2);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
